// File: rtl/camera_fifo_reader_if.sv
// Bundle of the camera FIFO read port, the pixel stream and the frame
// control strobes around camera_fifo_reader.
// master: the reader (pops bytes, drives the pixel stream).
// slave : the surroundings (FIFO, downstream pipeline, controller).
interface camera_fifo_reader_if #(
  parameter int H_BITS = 12,
  parameter int V_BITS = 11
);
  // Frame control
  logic              start;
  logic              busy;
  logic              frame_done;
  // FIFO read port
  logic              rd_en;
  logic              rd_vld;
  logic [7:0]        rd_data;
  // Pixel stream
  logic              pix_vld;
  logic              pix_rdy;
  logic [15:0]       pix_data;
  logic              pix_sof;
  logic              pix_eol;
  logic [H_BITS-1:0] x_cnt;
  logic [V_BITS-1:0] y_cnt;

  modport master (
    input  start, rd_vld, rd_data, pix_rdy,
    output busy, frame_done, rd_en, pix_vld, pix_data, pix_sof, pix_eol,
           x_cnt, y_cnt
  );

  modport slave (
    output start, rd_vld, rd_data, pix_rdy,
    input  busy, frame_done, rd_en, pix_vld, pix_data, pix_sof, pix_eol,
           x_cnt, y_cnt
  );
endinterface

// File: rtl/camera_fifo_reader.sv
// camera_fifo_reader: pops bytes from the camera prefetch FIFO, pairs them
// into 16-bit RGB565 pixels and emits one frame of pixels per start pulse,
// tagged with sof/eol markers and x/y position.
// Optional build macro CAMERA_FIFO_RD_SWAP_EN: pixel = {second, first} byte
// instead of the default {first, second}.
//
// Handshakes: a byte pops on any rising edge where rd_en && rd_vld; a pixel
// transfers on any rising edge where pix_vld && pix_rdy. pix_vld never drops
// without a transfer, and the pixel fields hold while pix_vld && !pix_rdy.
// rd_en is derived from registered state plus pix_rdy, never from rd_vld.
module camera_fifo_reader #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int H_BITS   = 12,
  parameter int V_BITS   = 11
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst_n,
  camera_fifo_reader_if.master bus,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [H_BITS-1:0] X_LAST = H_BITS'(H_ACTIVE - 1);
  localparam logic [V_BITS-1:0] Y_LAST = V_BITS'(V_ACTIVE - 1);

  state_t            state_q;
  logic              phase_q;     // 0: next pop is first byte, 1: second
  logic [7:0]        hi_q;        // first byte of the pixel being assembled
  logic [H_BITS-1:0] px_q;        // position of the next pixel to load
  logic [V_BITS-1:0] py_q;
  logic [H_BITS-1:0] px_d;
  logic [V_BITS-1:0] py_d;
  logic [15:0]       pair_d;
  logic              pix_vld_q;
  logic [15:0]       pix_data_q;
  logic              pix_sof_q;
  logic              pix_eol_q;
  logic [H_BITS-1:0] x_cnt_q;
  logic [V_BITS-1:0] y_cnt_q;
  logic              frame_done_q;
  logic              pop;
  logic              xfer;
  logic              at_last;

  // Pop request: first byte can always be taken; second byte only when the
  // output register is free or is being emptied this cycle.
  assign bus.rd_en = (state_q == ST_RUN) && (!phase_q || !pix_vld_q || bus.pix_rdy);
  assign pop       = bus.rd_en && bus.rd_vld;
  assign xfer      = pix_vld_q && bus.pix_rdy;
  assign at_last   = (px_q == X_LAST) && (py_q == Y_LAST);

  // Next raster position and byte-pair assembly.
  always_comb begin
    px_d = px_q + H_BITS'(1);
    py_d = py_q;
    if (px_q == X_LAST) begin
      px_d = '0;
      py_d = py_q + V_BITS'(1);
    end
`ifdef CAMERA_FIFO_RD_SWAP_EN
    pair_d = {bus.rd_data, hi_q};
`else
    pair_d = {hi_q, bus.rd_data};
`endif
  end

  // Frame FSM with byte pairing and the registered pixel output stage.
  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      state_q      <= ST_IDLE;
      phase_q      <= 1'b0;
      hi_q         <= '0;
      px_q         <= '0;
      py_q         <= '0;
      pix_vld_q    <= 1'b0;
      pix_data_q   <= '0;
      pix_sof_q    <= 1'b0;
      pix_eol_q    <= 1'b0;
      x_cnt_q      <= '0;
      y_cnt_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (xfer) pix_vld_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q <= ST_RUN;
            phase_q <= 1'b0;
            px_q    <= '0;
            py_q    <= '0;
          end
        end
        ST_RUN: begin
          if (pop && !phase_q) begin
            hi_q    <= bus.rd_data;
            phase_q <= 1'b1;
          end else if (pop) begin
            pix_vld_q  <= 1'b1;
            pix_data_q <= pair_d;
            pix_sof_q  <= (px_q == '0) && (py_q == '0);
            pix_eol_q  <= (px_q == X_LAST);
            x_cnt_q    <= px_q;
            y_cnt_q    <= py_q;
            phase_q    <= 1'b0;
            px_q       <= px_d;
            py_q       <= py_d;
            if (at_last) state_q <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (xfer) begin
            state_q      <= ST_IDLE;
            frame_done_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.frame_done = frame_done_q;
  assign bus.pix_vld    = pix_vld_q;
  assign bus.pix_data   = pix_data_q;
  assign bus.pix_sof    = pix_sof_q;
  assign bus.pix_eol    = pix_eol_q;
  assign bus.x_cnt      = x_cnt_q;
  assign bus.y_cnt      = y_cnt_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_camera_fifo_reader.sv
// Bench for camera_fifo_reader with a 4x2 frame. A byte-queue FIFO model
// feeds the DUT; expected pixels are computed from the byte stream and the
// raster geometry and checked by a separate monitor on every transfer.
module tb_camera_fifo_reader;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int HB = 3;
  localparam int VB = 2;
  localparam int NPIX  = H * V;
  localparam int NBYTE = 2 * NPIX;
  localparam int W = 2 + HB + VB + 16;   // {sof, eol, x, y, data}

  logic       clk;
  logic       rst_n;
  logic [1:0] state_o;

  camera_fifo_reader_if #(.H_BITS(HB), .V_BITS(VB)) bus ();

  camera_fifo_reader #(
    .H_ACTIVE(H), .V_ACTIVE(V), .H_BITS(HB), .V_BITS(VB)
  ) dut (
    .rd_clk  (clk),
    .rd_rst_n(rst_n),
    .bus     (bus),
    .state_o (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]   fifo_q[$];
  logic [W-1:0] exp_q[$];
  int           pops_total = 0;
  int           vld_mode   = 0;   // 0 always valid, 1 toggling, 2 random
  int           rdy_mode   = 0;   // 0 always ready, 1 random
  bit           rdy_hold   = 0;
  bit           start_req  = 0;
  bit           start_spam = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  // ---------------- driver: FIFO model and downstream ----------------
  bit avail, gate, tog, en_novld, pop_now;
  always begin
    @(negedge clk);
    avail = fifo_q.size() > 0;
    case (vld_mode)
      0:       gate = 1'b1;
      1:       begin tog = ~tog; gate = tog; end
      default: gate = 1'($urandom_range(0, 1));
    endcase
    bus.rd_data = avail ? fifo_q[0] : 8'h00;
    bus.pix_rdy = rdy_hold ? 1'b0 : ((rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
    bus.start   = start_req || (start_spam && bus.busy);
    bus.rd_vld  = 1'b0;
    #1;
    en_novld    = bus.rd_en;
    bus.rd_vld  = avail && gate;
    #1;
    if (vld_mode == 1 && rst_n) chk("rd_en_vs_rd_vld", 32'(bus.rd_en), 32'(en_novld));
    pop_now = bus.rd_en && bus.rd_vld;
    @(posedge clk);
    if (pop_now) begin
      void'(fifo_q.pop_front());
      pops_total++;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [W-1:0] got_w, exp_w, prev_w;
  bit           prev_stall = 0;
  bit           done_exp   = 0;
  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      got_w = {bus.pix_sof, bus.pix_eol, bus.x_cnt, bus.y_cnt, bus.pix_data};
      chk("frame_done", 32'(bus.frame_done), 32'(done_exp));
      if (done_exp) chk("busy_after_done", 32'(bus.busy), 32'd0);
      if (prev_stall) begin
        chk("hold_vld", 32'(bus.pix_vld), 32'd1);
        chk("hold_word", 32'(got_w), 32'(prev_w));
      end
      done_exp = 1'b0;
      if (bus.pix_vld && bus.pix_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pixel", 32'(got_w), 32'hFFFF_FFFF);
        end else begin
          exp_w = exp_q.pop_front();
          chk("pixel", 32'(got_w), 32'(exp_w));
          done_exp = (exp_w[20:18] == 3'(H - 1)) && (exp_w[17:16] == 2'(V - 1));
        end
      end
      prev_stall = bus.pix_vld && !bus.pix_rdy;
      prev_w     = got_w;
    end else begin
      prev_stall = 1'b0;
      done_exp   = 1'b0;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic begin_frame(input bit rnd, input logic [7:0] base);
    logic [7:0]  b[NBYTE];
    logic [15:0] d;
    for (int i = 0; i < NBYTE; i++) begin
      b[i] = rnd ? 8'($urandom) : base + 8'(i);
      fifo_q.push_back(b[i]);
    end
    for (int k = 0; k < NPIX; k++) begin
`ifdef CAMERA_FIFO_RD_SWAP_EN
      d = {b[2*k+1], b[2*k]};
`else
      d = {b[2*k], b[2*k+1]};
`endif
      exp_q.push_back({k == 0, (k % H) == H - 1, 3'(k % H), 2'(k / H), d});
    end
    // Two bytes of the following frame: must stay in the FIFO.
    fifo_q.push_back(8'($urandom));
    fifo_q.push_back(8'($urandom));
    pops_total = 0;
    start_req  = 1'b1;
    step();
    start_req  = 1'b0;
  endtask

  task automatic finish_frame(output int cycles);
    bit done = 0;
    cycles = 0;
    while (!done && cycles < 3000) begin
      step();
      cycles++;
      if (!bus.busy && exp_q.size() == 0) done = 1;
    end
    if (!done) chk("frame_timeout", 32'(cycles), 32'd0);
    step();
    step();
    chk("leftover_bytes", 32'(fifo_q.size()), 32'd2);
    fifo_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rd_en", 32'(bus.rd_en), 32'd0);
    chk("rst_pix_vld", 32'(bus.pix_vld), 32'd0);
    chk("rst_pix_data", 32'(bus.pix_data), 32'd0);
    chk("rst_sof", 32'(bus.pix_sof), 32'd0);
    chk("rst_eol", 32'(bus.pix_eol), 32'd0);
    chk("rst_x", 32'(bus.x_cnt), 32'd0);
    chk("rst_y", 32'(bus.y_cnt), 32'd0);
    chk("rst_done", 32'(bus.frame_done), 32'd0);
    chk("rst_state", 32'(state_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int cyc, n;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.rd_vld  = 1'b0;
    bus.rd_data = 8'h00;
    bus.pix_rdy = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk_reset_outputs();

    // Full rate, ordered bytes: one pixel per two cycles.
    vld_mode = 0; rdy_mode = 0;
    begin_frame(0, 8'h00);
    finish_frame(cyc);
    chk("full_rate_cycles", 32'(cyc), 32'(2 * NBYTE / 2 + 1));

    // Downstream stall right after the first pixel.
    rdy_hold = 1;
    begin_frame(0, 8'h00);
    n = 0;
    while (!bus.pix_vld && n < 100) begin step(); n++; end
    chk("first_pixel_seen", 32'(bus.pix_vld), 32'd1);
    repeat (10) step();
    chk("stall_pops", 32'(pops_total), 32'd3);
    chk("stall_rd_en", 32'(bus.rd_en), 32'd0);
    chk("stall_data", 32'(bus.pix_data), 32'h0001);
    rdy_hold = 0;
    finish_frame(cyc);

    // FIFO valid toggling every cycle.
    vld_mode = 1;
    begin_frame(0, 8'h00);
    finish_frame(cyc);

    // start held during RUN and FLUSH, random backpressure, then a new frame.
    vld_mode = 2; rdy_mode = 1; start_spam = 1;
    begin_frame(1, 8'h00);
    finish_frame(cyc);
    start_spam = 0;
    begin_frame(0, 8'h40);
    finish_frame(cyc);

    // Reset after five bytes popped, then a fresh frame.
    vld_mode = 0; rdy_mode = 0;
    begin_frame(0, 8'h50);
    n = 0;
    while (pops_total < 5 && n < 100) begin step(); n++; end
    chk("five_pops_reached", 32'(pops_total >= 5), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_reset_outputs();
    exp_q.delete();
    fifo_q.delete();
    step();
    begin_frame(0, 8'hA0);
    finish_frame(cyc);

    // Random frames with random flow control.
    for (int r = 0; r < 4; r++) begin
      vld_mode = $urandom_range(0, 2);
      rdy_mode = $urandom_range(0, 1);
      begin_frame(1, 8'h00);
      finish_frame(cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
